// File: rtl/am2302_poll_sched.sv
`default_nettype none
// ============================================================================
// Module      : am2302_poll_sched
// Description : Measurement sequencer for an AM2302_master. It issues
//               measurement requests periodically (auto mode) or on demand
//               (one-shot), retries failed attempts, and publishes
//               checksum-verified humidity/temperature through SFRs.
//   Ports     : clk/rst           - clock, asynchronous active-high reset
//               sfr_*             - CPU SFR bus (combinational read mux)
//               m_start/m_busy/m_done/m_err/m_data - AM2302_master handshake
//               irq               - registered IE & NEW
// Revision    : 1.0 - initial release
// ============================================================================
module am2302_poll_sched #(
    parameter logic [7:0]  SFR_CTRL   = 8'hC0,
    parameter logic [7:0]  SFR_STAT   = 8'hC1,
    parameter logic [7:0]  SFR_PERIOD = 8'hC2,
    parameter logic [7:0]  SFR_HUM_H  = 8'hC3,
    parameter logic [7:0]  SFR_HUM_L  = 8'hC4,
    parameter logic [7:0]  SFR_TMP_H  = 8'hC5,
    parameter logic [7:0]  SFR_TMP_L  = 8'hC6,
    parameter int unsigned TICK_DIV   = 307200,
    parameter int unsigned WD_TICKS   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sfr_addr,
    input  logic        sfr_wr,
    input  logic        sfr_rd,
    input  logic [7:0]  sfr_data_out,
    output logic [7:0]  sfr_data_in,
    output logic        m_start,
    input  logic        m_busy,
    input  logic        m_done,
    input  logic        m_err,
    input  logic [39:0] m_data,
    output logic        irq
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_INTERVAL   = 3'd1;
    localparam logic [2:0] S_START      = 3'd2;
    localparam logic [2:0] S_WAIT_DONE  = 3'd3;
    localparam logic [2:0] S_CHECK      = 3'd4;
    localparam logic [2:0] S_RETRY_WAIT = 3'd5;

    localparam logic [18:0] c_PRE_MAX     = 19'(TICK_DIV - 1);
    localparam logic [7:0]  c_WD_TICKS    = 8'(WD_TICKS);
    localparam logic [7:0]  c_RETRY_TICKS = 8'd20;
    localparam logic [7:0]  c_PERIOD_MIN  = 8'd20;
    localparam logic [1:0]  c_MAX_RETRY   = 2'd2;

    logic [18:0] r_pre;
    logic [2:0]  r_state;
    logic [7:0]  r_tcnt;
    logic        r_en, r_ie;
    logic [7:0]  r_period;
    logic        r_valid, r_new, r_ckerr, r_toerr;
    logic [2:0]  r_sretry;
    logic [1:0]  r_retry;
    logic        r_auto;
    logic        r_mstart;
    logic        r_irq;
    logic [39:0] r_frame;
    logic        r_ferr;
    logic [7:0]  r_hum_h, r_hum_l, r_tmp_h, r_tmp_l;
    logic [7:0]  r_sh_hum_l, r_sh_tmp_h, r_sh_tmp_l;

    logic        w_tick;
    logic        w_wr_ctrl, w_wr_stat, w_wr_period, w_rd_hum_h;
    logic        w_en_rise, w_oneshot;
    logic [7:0]  w_sum;
    logic        w_good;
    logic        w_no_retry;
    logic        w_busy;
    logic [2:0]  w_done_state;

    assign w_tick      = (r_pre == c_PRE_MAX);
    assign w_wr_ctrl   = sfr_wr && (sfr_addr == SFR_CTRL);
    assign w_wr_stat   = sfr_wr && (sfr_addr == SFR_STAT);
    assign w_wr_period = sfr_wr && (sfr_addr == SFR_PERIOD);
    assign w_rd_hum_h  = sfr_rd && (sfr_addr == SFR_HUM_H);
    assign w_en_rise   = w_wr_ctrl && sfr_data_out[0] && !r_en;
    assign w_oneshot   = w_wr_ctrl && sfr_data_out[1];
    assign w_sum       = r_frame[39:32] + r_frame[31:24] + r_frame[23:16] + r_frame[15:8];
    assign w_good      = !r_ferr && (w_sum == r_frame[7:0]);
    // An auto-mode measurement whose EN was dropped finishes its current
    // attempt but is not retried; one-shots always get their retries.
    assign w_no_retry  = (r_retry == c_MAX_RETRY) || (r_auto && !r_en);
    assign w_busy      = (r_state != S_IDLE) && (r_state != S_INTERVAL);
    assign w_done_state = r_en ? S_INTERVAL : S_IDLE;

    assign m_start = r_mstart;
    assign irq     = r_irq;

    // Free-running prescaler producing one tick every TICK_DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre <= 19'd0;
        end else if (w_tick) begin
            r_pre <= 19'd0;
        end else begin
            r_pre <= r_pre + 19'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tcnt     <= 8'd0;
            r_en       <= 1'b0;
            r_ie       <= 1'b0;
            r_period   <= c_PERIOD_MIN;
            r_valid    <= 1'b0;
            r_new      <= 1'b0;
            r_ckerr    <= 1'b0;
            r_toerr    <= 1'b0;
            r_sretry   <= 3'd0;
            r_retry    <= 2'd0;
            r_auto     <= 1'b0;
            r_mstart   <= 1'b0;
            r_irq      <= 1'b0;
            r_frame    <= 40'd0;
            r_ferr     <= 1'b0;
            r_hum_h    <= 8'd0;
            r_hum_l    <= 8'd0;
            r_tmp_h    <= 8'd0;
            r_tmp_l    <= 8'd0;
            r_sh_hum_l <= 8'd0;
            r_sh_tmp_h <= 8'd0;
            r_sh_tmp_l <= 8'd0;
        end else begin
            r_mstart <= 1'b0;
            r_irq    <= r_ie & r_new;

            if (w_wr_ctrl) begin
                r_en <= sfr_data_out[0];
                r_ie <= sfr_data_out[2];
            end
            if (w_wr_period) begin
                r_period <= (sfr_data_out < c_PERIOD_MIN) ? c_PERIOD_MIN : sfr_data_out;
            end
            // W1C clears come first so that an FSM set later in this block wins.
            if (w_wr_stat) begin
                if (sfr_data_out[2]) r_new   <= 1'b0;
                if (sfr_data_out[3]) r_ckerr <= 1'b0;
                if (sfr_data_out[4]) r_toerr <= 1'b0;
            end
            // Snapshot uses pre-update results, so a coincident CHECK load
            // shows up only on the following HUM_H read.
            if (w_rd_hum_h) begin
                r_sh_hum_l <= r_hum_l;
                r_sh_tmp_h <= r_tmp_h;
                r_sh_tmp_l <= r_tmp_l;
            end

            // Saturating tick counter; clears below take priority.
            if (w_tick && (r_tcnt != 8'hFF)) begin
                r_tcnt <= r_tcnt + 8'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_en_rise || w_oneshot) begin
                        r_state <= S_START;
                        r_auto  <= w_en_rise;
                        r_retry <= 2'd0;
                    end
                end
                S_INTERVAL: begin
                    if (!r_en) begin
                        r_state <= S_IDLE;
                    end else if (r_tcnt >= r_period) begin
                        r_state <= S_START;
                        r_auto  <= 1'b1;
                        r_retry <= 2'd0;
                    end
                end
                S_START: begin
                    if (!m_busy) begin
                        r_mstart <= 1'b1;
                        r_tcnt   <= 8'd0;
                        r_state  <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (m_done) begin
                        r_frame <= m_data;
                        r_ferr  <= m_err;
                        r_state <= S_CHECK;
                    end else if (r_tcnt >= c_WD_TICKS) begin
                        r_toerr <= 1'b1;
                        if (w_no_retry) begin
                            r_sretry <= 3'd3;
                            r_state  <= w_done_state;
                        end else begin
                            r_retry <= r_retry + 2'd1;
                            r_tcnt  <= 8'd0;
                            r_state <= S_RETRY_WAIT;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_good) begin
                        r_hum_h  <= r_frame[39:32];
                        r_hum_l  <= r_frame[31:24];
                        r_tmp_h  <= r_frame[23:16];
                        r_tmp_l  <= r_frame[15:8];
                        r_valid  <= 1'b1;
                        r_new    <= 1'b1;
                        r_sretry <= {1'b0, r_retry};
                        r_state  <= w_done_state;
                    end else begin
                        // A wire error makes the payload meaningless, so only
                        // a clean transfer with a bad sum counts as CKERR.
                        if (!r_ferr) r_ckerr <= 1'b1;
                        if (w_no_retry) begin
                            r_sretry <= 3'd3;
                            r_state  <= w_done_state;
                        end else begin
                            r_retry <= r_retry + 2'd1;
                            r_tcnt  <= 8'd0;
                            r_state <= S_RETRY_WAIT;
                        end
                    end
                end
                S_RETRY_WAIT: begin
                    if (r_auto && !r_en) begin
                        r_sretry <= 3'd3;
                        r_state  <= S_IDLE;
                    end else if (r_tcnt >= c_RETRY_TICKS) begin
                        r_state <= S_START;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Unmatched addresses read as zero so the bus can be ORed.
    always_comb begin
        sfr_data_in = 8'h00;
        case (sfr_addr)
            SFR_CTRL:   sfr_data_in = {5'd0, r_ie, 1'b0, r_en};
            SFR_STAT:   sfr_data_in = {r_sretry, r_toerr, r_ckerr, r_new, r_valid, w_busy};
            SFR_PERIOD: sfr_data_in = r_period;
            SFR_HUM_H:  sfr_data_in = r_hum_h;
            SFR_HUM_L:  sfr_data_in = r_sh_hum_l;
            SFR_TMP_H:  sfr_data_in = r_sh_tmp_h;
            SFR_TMP_L:  sfr_data_in = r_sh_tmp_l;
            default:    sfr_data_in = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_am2302_poll_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_am2302_poll_sched
// Description : Self-checking bench for am2302_poll_sched. A mock master
//               answers m_start from a response queue; outcomes of random
//               attempt sequences are predicted from the sequencing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_am2302_poll_sched;

    localparam int TD = 16;
    localparam logic [7:0] A_CTRL = 8'hC0, A_STAT = 8'hC1, A_PER = 8'hC2;
    localparam logic [7:0] A_HH = 8'hC3, A_HL = 8'hC4, A_TH = 8'hC5, A_TL = 8'hC6;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sfr_addr, sfr_data_out, sfr_data_in;
    logic        sfr_wr, sfr_rd;
    logic        m_start, m_busy, m_done, m_err, irq;
    logic [39:0] m_data;

    always #5 clk = ~clk;

    am2302_poll_sched #(.TICK_DIV(TD)) u_dut (
        .clk(clk), .rst(rst),
        .sfr_addr(sfr_addr), .sfr_wr(sfr_wr), .sfr_rd(sfr_rd),
        .sfr_data_out(sfr_data_out), .sfr_data_in(sfr_data_in),
        .m_start(m_start), .m_busy(m_busy), .m_done(m_done),
        .m_err(m_err), .m_data(m_data), .irq(irq)
    );

    typedef struct {
        int          dly;
        bit          drop;
        bit          err;
        logic [39:0] data;
    } rsp_t;

    rsp_t        rsp_q[$];
    int unsigned cyc = 0;
    int          n_start = 0;
    int unsigned start_cyc[$];
    int unsigned done_cyc[$];
    int          n_tests = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Mock AM2302 master: one queued response per m_start; empty queue = silence.
    initial begin : p_master
        rsp_t r;
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_data = '0;
        forever begin
            @(negedge clk);
            if (m_start === 1'b1) begin
                n_start++;
                start_cyc.push_back(cyc);
                if (rsp_q.size() > 0) begin
                    r = rsp_q.pop_front();
                end else begin
                    r.dly = 1; r.drop = 1'b1; r.err = 1'b0; r.data = '0;
                end
                if (!r.drop) begin
                    m_busy = 1'b1;
                    repeat (r.dly) @(negedge clk);
                    m_data = r.data; m_err = r.err; m_done = 1'b1;
                    done_cyc.push_back(cyc);
                    @(negedge clk);
                    m_done = 1'b0; m_busy = 1'b0; m_err = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        sfr_addr = a; sfr_data_out = d; sfr_wr = 1'b1;
        @(posedge clk);
        #1 sfr_wr = 1'b0;
    endtask

    task automatic sfr_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        sfr_addr = a; sfr_rd = 1'b1;
        #1 d = sfr_data_in;
        @(posedge clk);
        #1 sfr_rd = 1'b0;
    endtask

    task automatic read_results(output logic [31:0] r);
        logic [7:0] b;
        sfr_read(A_HH, b); r[31:24] = b;
        sfr_read(A_HL, b); r[23:16] = b;
        sfr_read(A_TH, b); r[15:8]  = b;
        sfr_read(A_TL, b); r[7:0]   = b;
    endtask

    task automatic wait_idle(input string tag);
        logic [7:0] s;
        int n;
        n = 0;
        do begin
            sfr_read(A_STAT, s);
            n++;
        end while (s[0] && n < 3000);
        chk({tag, "_busy_falls"}, 40'(s[0]), 40'd0);
    endtask

    task automatic push_rsp(input int dly, input bit drop, input bit err, input logic [39:0] data);
        rsp_t r;
        r.dly = dly; r.drop = drop; r.err = err; r.data = data;
        rsp_q.push_back(r);
    endtask

    // Frame with the byte-sum checksum, optionally corrupted by a nonzero XOR.
    function automatic logic [39:0] mk_frame(input logic [15:0] h, input logic [15:0] t, input bit bad);
        logic [7:0] ck;
        ck = h[15:8] + h[7:0] + t[15:8] + t[7:0];
        if (bad) ck = ck ^ 8'(1 + $urandom_range(0, 254));
        return {h, t, ck};
    endfunction

    initial begin : p_watchdog
        #900000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : p_main
        logic [7:0]  d;
        logic [31:0] res, exp_res;
        logic        exp_valid;
        int          base, dbase, n;
        rst = 1'b1; sfr_addr = '0; sfr_data_out = '0; sfr_wr = 1'b0; sfr_rd = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // ---- reset values
        sfr_read(A_CTRL, d); chk("rst_ctrl", 40'(d), 40'h00);
        sfr_read(A_STAT, d); chk("rst_stat", 40'(d), 40'h00);
        sfr_read(A_PER, d);  chk("rst_period", 40'(d), 40'h14);
        read_results(res);   chk("rst_results", 40'(res), 40'h0);
        chk("rst_irq", 40'(irq), 40'd0);
        chk("rst_mstart", 40'(m_start), 40'd0);

        // ---- one-shot good frame (02+8C+01+08 = 97)
        push_rsp(4, 1'b0, 1'b0, 40'h028C_0108_97);
        base = n_start;
        sfr_write(A_CTRL, 8'h06);
        wait_idle("os");
        chk("os_starts", 40'(n_start - base), 40'd1);
        read_results(res);   chk("os_results", 40'(res), 40'h028C_0108);
        sfr_read(A_STAT, d); chk("os_stat", 40'(d), 40'h06);
        chk("os_irq", 40'(irq), 40'd1);
        sfr_read(A_CTRL, d); chk("os_ctrl_oneshot_reads0", 40'(d), 40'h04);
        sfr_read(8'hC7, d);  chk("unmapped_zero", 40'(d), 40'h00);
        sfr_write(A_STAT, 8'h1C);
        sfr_read(A_STAT, d); chk("w1c_stat", 40'(d), 40'h02);
        chk("w1c_irq", 40'(irq), 40'd0);

        // ---- bad checksum then good
        push_rsp(5, 1'b0, 1'b0, 40'h0301_00F5_F8);
        push_rsp(3, 1'b0, 1'b0, 40'h0301_00F5_F9);
        base = n_start; dbase = done_cyc.size();
        sfr_write(A_CTRL, 8'h06);
        wait_idle("ck");
        chk("ck_starts", 40'(n_start - base), 40'd2);
        sfr_read(A_STAT, d); chk("ck_stat", 40'(d), 40'h2E);
        read_results(res);   chk("ck_results", 40'(res), 40'h0301_00F5);
        n = int'(start_cyc[base + 1] - done_cyc[dbase]);
        chk("ck_retry_gap_20ticks", 40'(n >= 19 * TD + 3 && n <= 20 * TD + 6), 40'd1);
        sfr_write(A_STAT, 8'h1C);

        // ---- master never answers
        base = n_start;
        sfr_write(A_CTRL, 8'h06);
        wait_idle("to");
        chk("to_starts", 40'(n_start - base), 40'd3);
        sfr_read(A_STAT, d); chk("to_stat", 40'(d), 40'h72);
        read_results(res);   chk("to_results_kept", 40'(res), 40'h0301_00F5);
        chk("to_irq", 40'(irq), 40'd0);
        n = int'(start_cyc[base + 1] - start_cyc[base]);
        chk("to_wd_plus_retry_gap", 40'(n >= 21 * TD + 2 && n <= 22 * TD + 3), 40'd1);
        sfr_write(A_STAT, 8'h1C);
        exp_res = 32'h0301_00F5;
        exp_valid = 1'b1;

        // ---- randomized attempt sequences against the outcome model
        for (int it = 0; it < 10; it++) begin
            int          typ[3];
            logic [15:0] hh[3], tt[3];
            int          g, p;
            bit          ck, to;
            logic [7:0]  exp_stat;
            base = n_start;
            for (int k = 0; k < 3; k++) begin
                p = int'($urandom_range(0, 9));
                typ[k] = (p < 4) ? 0 : (p < 6) ? 1 : (p < 8) ? 2 : 3; // good/badck/wire err/silent
                hh[k] = 16'($urandom);
                tt[k] = 16'($urandom);
                push_rsp(int'($urandom_range(1, 10)), typ[k] == 3, typ[k] == 2,
                         mk_frame(hh[k], tt[k], typ[k] == 1));
            end
            sfr_write(A_CTRL, 8'h06);
            wait_idle("rnd");
            rsp_q.delete();
            g = -1; ck = 1'b0; to = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (g < 0) begin
                    if (typ[k] == 0) g = k;
                    if (typ[k] == 1) ck = 1'b1;
                    if (typ[k] == 3) to = 1'b1;
                end
            end
            if (g >= 0) begin
                exp_res = {hh[g], tt[g]};
                exp_valid = 1'b1;
            end
            exp_stat = {(g < 0) ? 3'd3 : 3'(g), to, ck, g >= 0, exp_valid, 1'b0};
            chk("rnd_starts", 40'(n_start - base), 40'((g < 0) ? 3 : g + 1));
            sfr_read(A_STAT, d); chk("rnd_stat", 40'(d), 40'(exp_stat));
            read_results(res);   chk("rnd_results", 40'(res), 40'(exp_res));
            chk("rnd_irq", 40'(irq), 40'(g >= 0));
            sfr_write(A_STAT, 8'h1C);
        end

        // ---- coherency: shadows hold across a result update
        read_results(res); chk("coh_pre", 40'(res), 40'(exp_res));
        push_rsp(4, 1'b0, 1'b0, mk_frame(16'hA5C3, 16'h0F1E, 1'b0));
        sfr_write(A_CTRL, 8'h06);
        wait_idle("coh");
        sfr_read(A_TL, d); chk("coh_old_tmp_l", 40'(d), 40'(exp_res[7:0]));
        sfr_read(A_HH, d); chk("coh_new_hum_h", 40'(d), 40'hA5);
        sfr_read(A_TL, d); chk("coh_new_tmp_l", 40'(d), 40'h1E);
        sfr_write(A_STAT, 8'h1C);

        // ---- period clamp and auto-mode spacing
        sfr_write(A_PER, 8'h05); sfr_read(A_PER, d); chk("per_clamp_5", 40'(d), 40'h14);
        sfr_write(A_PER, 8'd19); sfr_read(A_PER, d); chk("per_clamp_19", 40'(d), 40'h14);
        sfr_write(A_PER, 8'd21); sfr_read(A_PER, d); chk("per_keep_21", 40'(d), 40'h15);
        sfr_write(A_PER, 8'd20);
        for (int k = 0; k < 8; k++) begin
            push_rsp(int'($urandom_range(1, 10)), 1'b0, 1'b0,
                     mk_frame(16'($urandom), 16'($urandom), 1'b0));
        end
        base = n_start;
        sfr_write(A_CTRL, 8'h01);
        n = 0;
        while (n_start < base + 4 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("auto_starts", 40'(n_start >= base + 4), 40'd1);
        sfr_write(A_CTRL, 8'h00);
        wait_idle("auto");
        rsp_q.delete();
        if (n_start >= base + 4) begin
            chk("auto_gap1", 40'(start_cyc[base + 2] - start_cyc[base + 1]), 40'(20 * TD));
            chk("auto_gap2", 40'(start_cyc[base + 3] - start_cyc[base + 2]), 40'(20 * TD));
        end
        sfr_read(A_STAT, d); chk("auto_stat", 40'(d), 40'h06);
        chk("auto_irq_masked", 40'(irq), 40'd0);

        // ---- reset during WAIT_DONE, m_done arrives afterwards
        push_rsp(6, 1'b0, 1'b0, mk_frame(16'h4242, 16'h1313, 1'b0));
        sfr_write(A_PER, 8'h30);
        base = n_start; dbase = done_cyc.size();
        sfr_write(A_CTRL, 8'h06);
        n = 0;
        while (n_start == base && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rm_started", 40'(n_start - base), 40'd1);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rm_done_pulsed", 40'(done_cyc.size() - dbase), 40'd1);
        sfr_read(A_CTRL, d); chk("rm_ctrl", 40'(d), 40'h00);
        sfr_read(A_STAT, d); chk("rm_stat", 40'(d), 40'h00);
        sfr_read(A_PER, d);  chk("rm_period", 40'(d), 40'h14);
        read_results(res);   chk("rm_results", 40'(res), 40'h0);
        chk("rm_irq", 40'(irq), 40'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
